// File: rtl/ifetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ifetch                                                       |
// | Description : Single-slot instruction fetch stage. Reads a 64-word         |
// |               combinational instruction memory at pc[7:2], registers the   |
// |               word with its PC and hands it downstream on a valid/ready    |
// |               handshake. Supports redirect, halt and a transfer counter.   |
// |               Optional macro IFETCH_ALIGN_CHECK_EN adds the align_err      |
// |               output and traps misaligned redirect targets.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_b,
  output logic [5:0]  imem_a,
  input  logic [31:0] imem_rd,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] fetch_cnt
`ifdef IFETCH_ALIGN_CHECK_EN
  ,
  output logic        align_err
`endif
);

  localparam logic [1:0] BOOT   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_valid;
  logic [15:0] r_fetch_cnt;

  logic        w_xfer;
  logic        w_free;
  logic        w_bad;
  logic [31:0] w_target;

  // Handshake: a transfer empties the slot so a new word can be captured in
  // the same cycle. The redirect target is forced to a word boundary.
  assign w_xfer   = r_valid & instr_ready;
  assign w_free   = ~r_valid | w_xfer;
  assign w_target = redirect_pc & 32'hFFFF_FFFC;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic r_align_err;

  assign w_bad     = (r_state != BOOT) & redirect & (redirect_pc[1:0] != 2'b00);
  assign align_err = r_align_err;

  // Sticky flag for a misaligned redirect target; cleared only by reset.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)   r_align_err <= 1'b0;
    else if (w_bad) r_align_err <= 1'b1;
  end
`else
  assign w_bad = 1'b0;
`endif

  // Memory address aliases onto 64 words regardless of pc[31:8].
  assign imem_a      = r_pc[7:2];
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;
  assign fetch_cnt   = r_fetch_cnt;

  // Transfer counter: every handshake counts, including one that coincides
  // with a redirect flush.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)    r_fetch_cnt <= 16'h0000;
    else if (w_xfer) r_fetch_cnt <= r_fetch_cnt + 16'h0001;
  end

  // Fetch control: BOOT idles one cycle; redirect beats halt and capture;
  // halt stops captures but lets the held word drain.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_instr    <= 32'h0000_0000;
      r_instr_pc <= 32'h0000_0000;
      r_valid    <= 1'b0;
    end else begin
      case (r_state)
        BOOT: begin
          r_state <= RUN;
        end
        RUN: begin
          if (redirect) begin
            r_valid <= 1'b0;
            if (w_bad) begin
              r_state <= HALTED;
            end else begin
              r_pc <= w_target;
              if (halt) r_state <= HALTED;
            end
          end else if (halt) begin
            r_state <= HALTED;
            if (w_xfer) r_valid <= 1'b0;
          end else if (w_free) begin
            r_instr    <= imem_rd;
            r_instr_pc <= r_pc;
            r_valid    <= 1'b1;
            r_pc       <= r_pc + 32'd4;
          end
        end
        HALTED: begin
          if (redirect) begin
            // Redirect while halted moves the PC but keeps the stage halted.
            r_valid <= 1'b0;
            if (!w_bad) r_pc <= w_target;
          end else begin
            if (w_xfer) r_valid <= 1'b0;
            if (!halt)  r_state <= RUN;
          end
        end
        default: begin
          r_state <= BOOT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
- REQ-001: Parameter RESET_PC, default 32'h00000000, is the PC loaded on reset.
- REQ-002: clk  input  1  is the single clock; all state updates on its rising edge.
- REQ-003: reset_b  input  1  is the asynchronous, active-low reset.
- REQ-004: imem_a  output  6  is the word address to instruction memory (combinational read), equal to pc[7:2].
- REQ-005: imem_rd  input  32  is the instruction word returned by instruction memory for imem_a in the same cycle.
- REQ-006: redirect  input  1  is a one-cycle request to load redirect_pc into the PC.
- REQ-007: redirect_pc  input  32  is the branch/jump target, sampled when redirect=1.
- REQ-008: halt  input  1  is a level request to stop fetching.
- REQ-009: instr  output  32  is the registered instruction.
- REQ-010: instr_pc  output  32  is the PC of instr.
- REQ-011: instr_valid  output  1  indicates that instr/instr_pc hold a fetched instruction.
- REQ-012: instr_ready  input  1  means downstream accepts instr this cycle.
- REQ-013: fetch_cnt  output  16  is the count of instructions handed downstream.

Function
- REQ-014: The FSM SHALL have the states BOOT, RUN and HALTED; BOOT SHALL last exactly one cycle after reset release and then go to RUN.
- REQ-015: A slot SHALL be free when instr_valid=0 or (instr_valid & instr_ready).
- REQ-016: In RUN, with a free slot and no redirect, the block SHALL capture imem_rd into instr and pc into instr_pc, set instr_valid=1, and set pc to pc+4, with 32-bit wrap-around.
- REQ-017: In RUN, when there is no free slot, pc, instr, instr_pc and instr_valid SHALL hold their values (stall).
- REQ-018: A transfer SHALL occur when instr_valid & instr_ready; fetch_cnt SHALL increment by 1 on each transfer and wrap from 16'hFFFF to 0.
- REQ-019: When redirect=1 in any state other than BOOT, pc SHALL become redirect_pc and instr_valid SHALL clear in the same edge; no capture SHALL occur that cycle.
- REQ-020: Redirect SHALL take priority over capture and over a simultaneous transfer; that transfer still counts in fetch_cnt.
- REQ-021: Latency SHALL be 1 cycle from pc update to instr_valid=1 for the first post-redirect instruction, so the first redirected instruction appears 2 edges after redirect.
- REQ-022: When halt=1 in RUN, the FSM SHALL go to HALTED with no further captures; a valid instr SHALL remain until transferred.
- REQ-023: In HALTED, the FSM SHALL return to RUN on the first cycle with halt=0; pc SHALL be unchanged.
- REQ-024: Redirect in HALTED SHALL update pc but SHALL NOT leave HALTED.
- REQ-025: Redirect during BOOT SHALL be ignored.
- REQ-026: When pc[31:8]!=0 (beyond the 64-word memory), the address SHALL still be pc[7:2] (aliasing); no error SHALL be raised.

Reset
- REQ-027: On reset_b=0, the block SHALL asynchronously set pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, fetch_cnt=0 and state=BOOT.
- REQ-028: Reset asserted mid-stall or mid-redirect SHALL discard all in-flight state with no transfer counted.

Configuration
- REQ-029: With macro IFETCH_ALIGN_CHECK_EN defined, an extra output align_err (1 bit, reset 0) SHALL exist, and a redirect with redirect_pc[1:0]!=0 SHALL set align_err sticky, force HALTED, and leave pc unchanged.
- REQ-030: Without IFETCH_ALIGN_CHECK_EN, the align_err port SHALL NOT exist, and redirect_pc[1:0] SHALL be ignored, with pc loaded as {redirect_pc[31:2],2'b00}.

Verification
- REQ-031: Reset release with instr_ready=1 held and memory word n = 32'h1000_0000+n: instr_valid=1 from the 2nd edge, instr_pc=0,4,8..., and instr = 32'h10000000, 32'h10000001, ...
- REQ-032: instr_ready=0 for 3 cycles at instr_pc=8: instr, instr_pc and imem_a held, fetch_cnt frozen; resume at pc=12 with no instruction lost or duplicated.
- REQ-033: redirect=1 with redirect_pc=32'h40 while instr_ready=1: the next edge has instr_valid=0, the following edge has instr_pc=32'h40, and the transfer in the redirect cycle is counted.
- REQ-034: halt=1 for 4 cycles then 0: no captures while halted; the held instr transfers once; fetch resumes at the same pc.
- REQ-035: With IFETCH_ALIGN_CHECK_EN defined, redirect_pc=32'h42 gives align_err=1 and HALTED, pc unchanged; reset_b=0 clears it. Without the macro, redirect_pc=32'h42 loads pc=32'h40.
